sweep_capture: RTL and testbench
================================

// Module: sweep_capture
// PURPOSE
// Read side of a DAC sweep: collects ADC samples while sweep holds each output
// point, skips a settling window, and sums a fixed number of samples per point.
// Each completed point is a (index, sum, count) record on a valid/ready port;
// downstream divides sum by count. Shares o_stepping and repeats/steps with sweep.
// PARAMETERS
// DATA_W  12         ADC sample width
// CNT_W   12         width of settle/repeats/steps counters and point index
// ACC_W   DATA_W+CNT_W  accumulator width; full scale for 2^CNT_W-1 samples
// PORTS
// i_stepCLK      in   1      sole clock, rising edge
// i_reset_n      in   1      async active-low reset
// i_arm          in   1      1-cycle pulse: arm a capture (IDLE/DONE only)
// i_stepping     in   1      sweep running flag (from sweep o_stepping)
// i_sample_valid in   1      ADC sample strobe, 1 cycle per sample
// i_sample       in   DATA_W ADC sample, qualified by i_sample_valid
// i_settle       in   CNT_W  samples discarded at start of each point
// i_repeats      in   CNT_W  samples summed per point (0 treated as 1)
// i_steps        in   CNT_W  points per sweep
// o_valid        out  1      point record available
// i_ready        in   1      downstream accepts record when o_valid&&i_ready
// o_index        out  CNT_W  point index, 0..i_steps-1
// o_sum          out  ACC_W  sum of accumulated samples
// o_count        out  CNT_W  samples in o_sum (= effective repeats)
// o_busy         out  1      high in ARMED or ACCUM
// o_done         out  1      high in DONE
// o_overrun      out  1      sticky: record overwritten before accept
// o_aborted      out  1      sticky: i_stepping fell mid-sweep
// BEHAVIOUR
// - Reset: state IDLE; all counters, accumulator, o_* outputs 0.
// - i_settle/i_repeats/i_steps sampled into regs on i_arm; changes ignored after.
// - i_arm also clears o_overrun, o_aborted, o_done; ignored in ARMED/ACCUM.
// - IDLE -i_arm-> ARMED. ARMED -i_stepping==1-> ACCUM (idx=0, phase=settle).
// - ARMED with latched steps==0: on i_stepping -> DONE, no records.
// - ACCUM per accepted sample: settle phase counts i_settle samples (none if 0),
//   then sum phase adds i_sample zero-extended to ACC_W, count++.
// - Sample making count==repeats: record {idx,sum+sample,repeats} registered,
//   o_valid=1 next cycle (1-cycle latency); acc=0, phase=settle, idx++.
// - Record for idx==steps-1 completes -> DONE next cycle; DONE -i_arm-> ARMED.
// - i_stepping==0 in ACCUM: -> IDLE, partial point discarded, o_aborted=1;
//   records already emitted stay valid. Fall after last point is normal.
// - Handshake: o_valid held with stable data until o_valid&&i_ready; new
//   record on same cycle as accept -> o_valid stays 1 with new data.
// - New record while o_valid&&!i_ready: overwrite, o_overrun=1 (sticky).
// - i_sample_valid outside ACCUM ignored. No wrap: ACC_W holds max sum.
// - Async reset mid-sweep: immediate IDLE, pending record dropped.
// TESTING
// - settle=2,repeats=4,steps=3; samples 1..18 -> sums 18,42,66, idx 0,1,2, count 4, o_done.
// - repeats=0, steps=2, samples 7,9 (settle=0) -> records sum 7 then 9, count 1.
// - i_ready low across 2 records -> 2nd record shown, o_overrun=1; 1st lost.
// - i_stepping drops after point 1 of 4 -> IDLE, o_aborted=1, no further records.
// - steps=4095, repeats=4095, all samples 12'hFFF -> sum 24'hFFE001 each, no wrap.
// - i_reset_n low mid-ACCUM with o_valid=1 -> all outputs 0 immediately; i_arm rearms.

Source files
------------

// File: rtl/sweep_capture_if.sv
// Capture-side port bundle: control/config and ADC sample inputs, point-record outputs.
// The slave modport is the capture block; the master modport is the sweep controller or bench.
interface sweep_capture_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 12,
  parameter int ACC_W  = DATA_W + CNT_W
) ();
  logic              arm;
  logic              stepping;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic [CNT_W-1:0]  settle;
  logic [CNT_W-1:0]  repeats;
  logic [CNT_W-1:0]  steps;
  logic              valid;
  logic              ready;
  logic [CNT_W-1:0]  index;
  logic [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
  logic              overrun;
  logic              aborted;

  modport slave (
    input  arm, stepping, sample_valid, sample, settle, repeats, steps, ready,
    output valid, index, sum, count, busy, done, overrun, aborted
  );

  modport master (
    output arm, stepping, sample_valid, sample, settle, repeats, steps, ready,
    input  valid, index, sum, count, busy, done, overrun, aborted
  );
endinterface

// File: rtl/sweep_capture.sv
// Per-point ADC sample accumulator for a DAC sweep: skips a settling window, sums a
// fixed number of samples per point and emits (index, sum, count) on a valid/ready port.
module sweep_capture #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 12,
  parameter int ACC_W  = DATA_W + CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  sweep_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, ACCUM, DONE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  settle_reg;
  logic [CNT_W-1:0]  repeats_reg;
  logic [CNT_W-1:0]  steps_reg;
  logic [CNT_W-1:0]  settle_cnt_reg;
  logic [CNT_W-1:0]  sum_cnt_reg;
  logic [CNT_W-1:0]  idx_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic              valid_reg;
  logic [CNT_W-1:0]  index_reg;
  logic [ACC_W-1:0]  sum_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              overrun_reg;
  logic              aborted_reg;

  logic [ACC_W-1:0]  sum_next;
  logic [CNT_W-1:0]  sum_cnt_next;
  logic [CNT_W-1:0]  steps_last;

  // ACC_W is sized for a full-scale sum of 2^CNT_W-1 samples, so this never wraps.
  assign sum_next     = acc_reg + ACC_W'(bus.sample);
  assign sum_cnt_next = sum_cnt_reg + CNT_W'(1);
  assign steps_last   = steps_reg - CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      settle_reg     <= '0;
      repeats_reg    <= '0;
      steps_reg      <= '0;
      settle_cnt_reg <= '0;
      sum_cnt_reg    <= '0;
      idx_reg        <= '0;
      acc_reg        <= '0;
      valid_reg      <= 1'b0;
      index_reg      <= '0;
      sum_reg        <= '0;
      count_reg      <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
      aborted_reg    <= 1'b0;
    end else begin
      if (valid_reg && bus.ready) begin
        valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE, DONE: begin
          if (bus.arm) begin
            settle_reg  <= bus.settle;
            repeats_reg <= (bus.repeats == '0) ? CNT_W'(1) : bus.repeats;
            steps_reg   <= bus.steps;
            overrun_reg <= 1'b0;
            aborted_reg <= 1'b0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= ARMED;
          end
        end

        ARMED: begin
          if (bus.stepping) begin
            idx_reg        <= '0;
            acc_reg        <= '0;
            settle_cnt_reg <= '0;
            sum_cnt_reg    <= '0;
            if (steps_reg == '0) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end

        ACCUM: begin
          if (!bus.stepping) begin
            // Sweep stopped before the last point: drop the partial point.
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b1;
            state_reg   <= IDLE;
          end else if (bus.sample_valid) begin
            if (settle_cnt_reg != settle_reg) begin
              settle_cnt_reg <= settle_cnt_reg + CNT_W'(1);
            end else if (sum_cnt_next == repeats_reg) begin
              index_reg <= idx_reg;
              sum_reg   <= sum_next;
              count_reg <= repeats_reg;
              valid_reg <= 1'b1;
              if (valid_reg && !bus.ready) begin
                overrun_reg <= 1'b1;
              end
              acc_reg        <= '0;
              sum_cnt_reg    <= '0;
              settle_cnt_reg <= '0;
              idx_reg        <= idx_reg + CNT_W'(1);
              if (idx_reg == steps_last) begin
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                state_reg <= DONE;
              end
            end else begin
              acc_reg     <= sum_next;
              sum_cnt_reg <= sum_cnt_next;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.valid   = valid_reg;
  assign bus.index   = index_reg;
  assign bus.sum     = sum_reg;
  assign bus.count   = count_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.overrun = overrun_reg;
  assign bus.aborted = aborted_reg;

endmodule

// File: tb/tb_sweep_capture.sv
// Directed bench for sweep_capture: nominal sweep, repeats=0, overrun, abort,
// full-scale sums and asynchronous reset mid-point.
module tb_sweep_capture;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   fail_cnt;
  int   total_cnt;

  sweep_capture_if #(.DATA_W(12), .CNT_W(12), .ACC_W(24)) bus ();

  sweep_capture #(.DATA_W(12), .CNT_W(12), .ACC_W(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int v);
    bus.sample_valid = 1'b1;
    bus.sample       = 12'(v);
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic arm_capture(input int st, input int rp, input int sp);
    bus.settle  = 12'(st);
    bus.repeats = 12'(rp);
    bus.steps   = 12'(sp);
    bus.arm     = 1'b1;
    tick();
    bus.arm     = 1'b0;
  endtask

  int exp_sum1 [3] = '{18, 42, 66};

  initial begin
    pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
    rst_n = 1'b0;
    bus.arm = 1'b0; bus.stepping = 1'b0; bus.sample_valid = 1'b0; bus.sample = '0;
    bus.settle = '0; bus.repeats = '0; bus.steps = '0; bus.ready = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_sum", 32'(bus.sum), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    rst_n = 1'b1;
    tick();

    // Nominal sweep: settle=2, repeats=4, steps=3, samples 1..18
    arm_capture(2, 4, 3);
    chk("t1_busy_armed", 32'(bus.busy), 1);
    bus.stepping = 1'b1;
    tick();
    for (int s = 1; s <= 18; s++) begin
      send(s);
      if (s % 6 == 0) begin
        $display("t1 record idx=%0d sum=%0d count=%0d", bus.index, bus.sum, bus.count);
        chk("t1_valid", 32'(bus.valid), 1);
        chk("t1_index", 32'(bus.index), 32'(s / 6 - 1));
        chk("t1_sum", 32'(bus.sum), 32'(exp_sum1[s / 6 - 1]));
        chk("t1_count", 32'(bus.count), 4);
      end
    end
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_busy_end", 32'(bus.busy), 0);
    tick();
    chk("t1_valid_accepted", 32'(bus.valid), 0);
    bus.stepping = 1'b0;
    tick();
    chk("t1_no_abort_after_last", 32'(bus.aborted), 0);

    // repeats=0 treated as 1; back-to-back records with accept on same cycle
    arm_capture(0, 0, 2);
    chk("t2_done_cleared", 32'(bus.done), 0);
    bus.stepping = 1'b1;
    tick();
    send(7);
    $display("t2 record idx=%0d sum=%0d count=%0d", bus.index, bus.sum, bus.count);
    chk("t2_sum0", 32'(bus.sum), 7);
    chk("t2_count0", 32'(bus.count), 1);
    chk("t2_index0", 32'(bus.index), 0);
    send(9);
    $display("t2 record idx=%0d sum=%0d count=%0d", bus.index, bus.sum, bus.count);
    chk("t2_valid1", 32'(bus.valid), 1);
    chk("t2_sum1", 32'(bus.sum), 9);
    chk("t2_index1", 32'(bus.index), 1);
    chk("t2_done", 32'(bus.done), 1);
    chk("t2_no_overrun", 32'(bus.overrun), 0);
    tick();
    bus.stepping = 1'b0;
    tick();

    // Overrun: ready low across two records
    bus.ready = 1'b0;
    arm_capture(0, 1, 2);
    bus.stepping = 1'b1;
    tick();
    send(5);
    chk("t3_sum0", 32'(bus.sum), 5);
    chk("t3_overrun0", 32'(bus.overrun), 0);
    send(6);
    $display("t3 record idx=%0d sum=%0d overrun=%0d", bus.index, bus.sum, bus.overrun);
    chk("t3_valid", 32'(bus.valid), 1);
    chk("t3_sum1", 32'(bus.sum), 6);
    chk("t3_index1", 32'(bus.index), 1);
    chk("t3_overrun1", 32'(bus.overrun), 1);
    tick();
    chk("t3_valid_held", 32'(bus.valid), 1);
    bus.ready = 1'b1;
    tick();
    chk("t3_valid_accepted", 32'(bus.valid), 0);
    chk("t3_overrun_sticky", 32'(bus.overrun), 1);
    bus.stepping = 1'b0;
    tick();

    // Abort after point 0 of 4, mid-way through point 1
    arm_capture(1, 2, 4);
    chk("t4_overrun_cleared", 32'(bus.overrun), 0);
    bus.stepping = 1'b1;
    tick();
    send(10); send(20); send(30);
    $display("t4 record idx=%0d sum=%0d", bus.index, bus.sum);
    chk("t4_sum0", 32'(bus.sum), 50);
    chk("t4_count0", 32'(bus.count), 2);
    send(40);
    send(50);
    bus.stepping = 1'b0;
    tick();
    chk("t4_aborted", 32'(bus.aborted), 1);
    chk("t4_busy", 32'(bus.busy), 0);
    chk("t4_done", 32'(bus.done), 0);
    send(60); send(70); send(80);
    chk("t4_no_more_records", 32'(bus.valid), 0);

    // Full-scale sums, then async reset while a record is pending
    arm_capture(0, 4095, 4095);
    chk("t5_aborted_cleared", 32'(bus.aborted), 0);
    bus.stepping = 1'b1;
    tick();
    for (int i = 0; i < 8190; i++) begin
      send(12'hFFF);
      if (i == 4094 || i == 8189) begin
        $display("t5 record idx=%0d sum=%0h count=%0d", bus.index, bus.sum, bus.count);
        chk("t5_valid", 32'(bus.valid), 1);
        chk("t5_sum", 32'(bus.sum), 32'h00FFE001);
        chk("t5_count", 32'(bus.count), 4095);
        chk("t5_index", 32'(bus.index), (i == 4094) ? 0 : 1);
      end
    end
    chk("t5_busy_mid", 32'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid_async", 32'(bus.valid), 0);
    chk("t6_sum_async", 32'(bus.sum), 0);
    chk("t6_index_async", 32'(bus.index), 0);
    chk("t6_count_async", 32'(bus.count), 0);
    chk("t6_busy_async", 32'(bus.busy), 0);
    bus.stepping = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    arm_capture(0, 1, 1);
    chk("t6_rearm_busy", 32'(bus.busy), 1);
    bus.stepping = 1'b1;
    tick();
    send(3);
    $display("t6 record idx=%0d sum=%0d", bus.index, bus.sum);
    chk("t6_rearm_sum", 32'(bus.sum), 3);
    chk("t6_rearm_done", 32'(bus.done), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
